// File: rtl/input_port_unit_pkg.sv
// Shared NoC definitions: flit type codes, output/switch port codes, dest-field
// bit positions, input-port FSM states and the XY route helper.
package input_port_unit_pkg;

  localparam logic [1:0] FLIT_HEAD   = 2'b10;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam logic [2:0] OUT_LOCAL_PORT = 3'd0;
  localparam logic [2:0] OUT_X1_PORT    = 3'd1;
  localparam logic [2:0] OUT_X2_PORT    = 3'd2;
  localparam logic [2:0] OUT_Y1_PORT    = 3'd3;

  localparam logic [2:0] SW_LOCAL = 3'd0;
  localparam logic [2:0] SW_X1    = 3'd1;
  localparam logic [2:0] SW_X2    = 3'd2;
  localparam logic [2:0] SW_Y1    = 3'd3;
  localparam logic [2:0] SW_NONE  = 3'd7;

  localparam int DEST_X_HI  = 2;
  localparam int DEST_X_LO  = 1;
  localparam int DEST_Y_BIT = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ipu_state_e;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [2:0] xy_route(input logic [1:0] dst_x, input logic dst_y,
                                          input logic [1:0] cur_x, input logic cur_y);
    if (dst_x < cur_x)      return OUT_X1_PORT;
    else if (dst_x > cur_x) return OUT_X2_PORT;
    else if (dst_y != cur_y) return OUT_Y1_PORT;
    else                    return OUT_LOCAL_PORT;
  endfunction

endpackage

// File: rtl/input_port_unit_flit_fifo.sv
// Synchronous flit FIFO; a write while full is accepted only if a read frees a slot
// in the same cycle. Read data is the head entry (no write-through bypass).
module input_port_unit_flit_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [FLIT_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_rd, do_wr;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: buffers flits, requests the XY output for each packet,
// holds the route for the wormhole, pops one flit per grant and returns credits.
module input_port_unit
  import input_port_unit_pkg::*;
#(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              sw_grant,
  output logic [2:0]        port_dst,
  output logic              port_en,
  output logic [FLIT_W-1:0] flit_out,
  output logic              credit_out,
  output logic              ovf_err,
  output logic              proto_err
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0]    CUR_XL  = CUR_X[1:0];
  localparam logic          CUR_YL  = CUR_Y[0];

  ipu_state_e    state_q, state_d;
  logic [2:0]    route_q, route_d;
  logic          credit_q, credit_d;
  logic          ovf_q, ovf_d;
  logic          proto_q, proto_d;
  logic          pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [1:0]    head_type;
  logic [2:0]    head_route;
  logic          head_starts_pkt;

  input_port_unit_flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_flit_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (in_flit),
    .rd_en   (pop),
    .rd_data (flit_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head_type       = flit_out[FLIT_W-1:FLIT_W-2];
  assign head_route      = xy_route(flit_out[DEST_X_HI:DEST_X_LO], flit_out[DEST_Y_BIT],
                                    CUR_XL, CUR_YL);
  assign head_starts_pkt = (head_type == FLIT_HEAD) || (head_type == FLIT_SINGLE);

  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    port_en  = 1'b0;
    port_dst = OUT_LOCAL_PORT;
    pop      = 1'b0;
    proto_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        port_en = en & ~fifo_empty & head_starts_pkt;
        if (!fifo_empty) port_dst = head_route;
        if (port_en && sw_grant) begin
          pop = 1'b1;
          if (head_type == FLIT_HEAD) begin
            state_d = ST_ACTIVE;
            route_d = head_route;
          end
        end else if (en && !fifo_empty && !head_starts_pkt) begin
          // Orphan BODY/TAIL: drop it without a request but still free the slot.
          pop     = 1'b1;
          proto_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        port_en  = en & ~fifo_empty;
        port_dst = route_q;
        if (port_en && sw_grant) begin
          pop = 1'b1;
          if (head_type == FLIT_TAIL) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    credit_d = pop;
    ovf_d    = in_valid & fifo_full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      route_q  <= OUT_LOCAL_PORT;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      route_q  <= route_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      proto_q  <= proto_d;
    end
  end

  assign credit_out = credit_q;
  assign ovf_err    = ovf_q;
  assign proto_err  = proto_q;

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_count <= DEPTH_C) && (fifo_full == (fifo_count == DEPTH_C)));

endmodule

// File: doc/input_port_unit.md
Name: input_port_unit

Overview:
- Router input-side unit for the 2x4 mesh NoC: buffers incoming flits in a FIFO, computes the XY route on head flits, and drives the per-input destination/request pair (port_*_dst, port_*_en) consumed by switch_allocation_3port/4port.
- Holds the route for the whole wormhole packet and pops one flit per grant.
- Returns one credit per pop to the upstream router.
- One instance per router input (X1, X2, Y1, LOCAL); its flit_out feeds the crossbar.

Parameters:
- FLIT_W, 32, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type, bits [2:1] are dest X, bit [0] is dest Y.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- CUR_X, 0, this router's X coordinate (0..3).
- CUR_Y, 0, this router's Y coordinate (0..1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  global enable; when 0, no request is made and no pop occurs
- in_valid  in  1  upstream flit write strobe
- in_flit  in  FLIT_W  incoming flit
- sw_grant  in  1  allocator granted this input this cycle (decoded from out_*_sw by router top)
- port_dst  out  3  requested output, using `OUT_LOCAL_PORT/`OUT_X1_PORT/`OUT_X2_PORT/`OUT_Y1_PORT
- port_en  out  1  request valid
- flit_out  out  FLIT_W  FIFO head flit, to crossbar
- credit_out  out  1  one-cycle pulse per popped flit
- ovf_err  out  1  one-cycle pulse: write dropped because FIFO full
- proto_err  out  1  one-cycle pulse: non-head flit discarded in IDLE

Behaviour:
- Reset (rst_n=0 at posedge): FIFO empty (rd/wr pointers and count = 0), state IDLE, route register = `OUT_LOCAL_PORT. Outputs port_en=0, port_dst=`OUT_LOCAL_PORT, credit_out=0, ovf_err=0, proto_err=0. flit_out is don't-care while empty. Reset mid-packet discards all buffered flits and issues no credits for them.
- Flit types: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
- Write: when in_valid=1 and count<DEPTH, the flit is stored at the posedge. When full and no pop in the same cycle, the write is dropped and ovf_err pulses next cycle. Full with a pop in the same cycle: write accepted, count unchanged.
- A written flit is visible on flit_out/port_en no earlier than the next cycle; there is no bypass.
- Route (combinational on FIFO head in IDLE):
  - dst_x<CUR_X gives X1.
  - dst_x>CUR_X gives X2.
  - dst_x==CUR_X and dst_y!=CUR_Y gives Y1.
  - Otherwise LOCAL.
- FSM IDLE:
  - port_en = en & !empty & head type in {HEAD, SINGLE}; port_dst = computed route.
  - Grant on HEAD: pop, latch route, go to ACTIVE.
  - Grant on SINGLE: pop, stay in IDLE.
  - BODY/TAIL at head: popped without request (only when en=1), proto_err pulses next cycle, credit still returned.
- FSM ACTIVE:
  - port_en = en & !empty; port_dst = latched route.
  - Grant on BODY: pop, stay in ACTIVE.
  - Grant on TAIL: pop, go to IDLE.
  - HEAD/SINGLE at head is treated as BODY (no error; the upstream guarantees ordering).
- sw_grant is honoured only when port_en=1 in the same cycle; otherwise it is ignored.
- Throughput: one flit per cycle under continuous grant.
- credit_out is registered and pulses the cycle after each pop, including proto_err discards.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package/global.v holds: flit type codes (`FLIT_HEAD/BODY/TAIL/SINGLE), the existing `OUT_*_PORT and `SW_* codes, and the dest-field bit positions.
- One natural sub-module: flit_fifo (parameterised FLIT_W/DEPTH synchronous FIFO with full/empty/count).
- Route compute and FSM stay in input_port_unit.

Test Plan:
- CUR_X=1, CUR_Y=0; write SINGLE with dst_x=3, dst_y=0; grant held 1 -> port_en=1 and port_dst=`OUT_X2_PORT the cycle after the write; pop on grant; credit_out pulse 1 cycle later; port_en=0 afterwards.
- HEAD(dst 1,1), BODY, BODY, TAIL written back-to-back; grant every cycle -> port_dst=`OUT_Y1_PORT for 4 consecutive cycles; exactly 4 credit pulses; state returns to IDLE.
- Same 4-flit packet with grant only on alternate cycles -> port_en stays 1 throughout; flit_out advances only on granted cycles; route unchanged while a following HEAD(dst 0,0) waits behind the TAIL, then port_dst=`OUT_X1_PORT.
- DEPTH=4: write 5 flits with no grant -> 5th dropped; ovf_err pulses once; count=4. Then simultaneous write and grant -> count stays 4 and ovf_err=0.
- FIFO holds BODY in IDLE -> port_en=0; flit discarded; proto_err and credit_out pulse; the next HEAD is routed normally.
- Reset asserted mid-packet with 3 flits buffered -> next cycle port_en=0, empty, no credits. A HEAD(dst=CUR) after reset gives port_dst=`OUT_LOCAL_PORT. Also: en=0 with grant -> no pop.
